// File: rtl/format9_pkg.sv
// Shared constants and types for the format9 multiply-add accumulator.
package format9_pkg;

  // bf16-layout product fields
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;

  // FP32 accumulator fields
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  // Datapath widths: 24-bit significand, 3 guard bits, 1 carry bit
  localparam int SIG_W = 24;
  localparam int ALN_W = 27;
  localparam int SUM_W = 28;

  // out_flags bit positions: {nan, inf, overflow}
  localparam int FLAG_OVF = 0;
  localparam int FLAG_INF = 1;
  localparam int FLAG_NAN = 2;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ALIGN = 2'd1,
    S_NORM  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/format9_lzc28.sv
// Combinational 28-bit leading-zero counter; an all-zero input returns 28.
module format9_lzc28
  import format9_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [4:0]       count
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < SUM_W; i++) begin
      if (value[i]) count = 5'(SUM_W - 1 - i);
    end
  end

endmodule

// File: rtl/format9_madd_accum.sv
// Accumulates a framed stream of bf16-layout products into an FP32 sum,
// one product every three cycles, and hands the result out on valid/ready.
module format9_madd_accum
  import format9_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_pab,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [2:0]       out_flags
);

  state_t state, nxt_state;

  logic [15:0]      pab_q;
  logic             last_q;
  logic [31:0]      acc;
  logic [CNT_W-1:0] count;
  logic [2:0]       flags;

  // Aligned operands carried from S_ALIGN into S_NORM
  logic [ALN_W-1:0] al_big, al_sml;
  logic [7:0]       al_exp;
  logic             al_sign, al_sub;

  // Field unpack of accumulator and captured product
  logic             acc_s, prd_s;
  logic [7:0]       acc_e, prd_e;
  logic [SIG_W-1:0] acc_m, prd_m;
  logic             acc_nan, acc_inf, prd_nan, prd_inf;

  assign acc_s   = acc[31];
  assign acc_e   = acc[30:23];
  assign acc_m   = {acc_e != 8'd0, acc[22:0]};
  assign prd_s   = pab_q[15];
  assign prd_e   = pab_q[14:7];
  assign prd_m   = {prd_e != 8'd0, pab_q[6:0], 16'b0};
  assign acc_nan = (acc_e == 8'(EXP_MAX)) && (acc[22:0] != '0);
  assign acc_inf = (acc_e == 8'(EXP_MAX)) && (acc[22:0] == '0);
  assign prd_nan = (prd_e == 8'(EXP_MAX)) && (pab_q[6:0] != '0);
  assign prd_inf = (prd_e == 8'(EXP_MAX)) && (pab_q[6:0] == '0);

  // Align: larger magnitude first so the later subtract never goes negative
  logic             acc_big;
  logic [7:0]       big_e, sml_e, diff;
  logic [SIG_W-1:0] big_m, sml_m;
  logic [ALN_W-1:0] sml_sh;
  always_comb begin
    acc_big = {acc_e, acc_m} >= {prd_e, prd_m};
    big_e   = acc_big ? acc_e : prd_e;
    sml_e   = acc_big ? prd_e : acc_e;
    big_m   = acc_big ? acc_m : prd_m;
    sml_m   = acc_big ? prd_m : acc_m;
    diff    = big_e - sml_e;
    sml_sh  = (diff > 8'd26) ? '0 : ({sml_m, 3'b000} >> diff);
  end

  // Add/subtract, normalize with the leading-zero count, truncate to 23 bits
  logic [SUM_W-1:0]  sum;
  logic [4:0]        lz;
  logic signed [9:0] res_exp;
  logic [22:0]       frac;

  always_comb begin
    sum     = al_sub ? ({1'b0, al_big} - {1'b0, al_sml})
                     : ({1'b0, al_big} + {1'b0, al_sml});
    // Leading one lands on bit 27 after the shift, hence the +1
    res_exp = $signed({2'b00, al_exp}) + 10'sd1 - $signed({5'b00000, lz});
    frac    = 23'((sum << lz) >> 4);
  end

  format9_lzc28 u_lzc (
    .value (sum),
    .count (lz)
  );

  // Result selection: specials first, then finite overflow/underflow
  logic [31:0] nxt_acc;
  logic [2:0]  nxt_flags;
  always_comb begin
    nxt_acc   = acc;
    nxt_flags = flags;
    if (prd_inf) nxt_flags[FLAG_INF] = 1'b1;
    if (acc_nan || prd_nan) begin
      nxt_acc             = FP32_QNAN;
      nxt_flags[FLAG_NAN] = 1'b1;
    end else if (acc_inf && prd_inf && (acc_s != prd_s)) begin
      nxt_acc             = FP32_QNAN;
      nxt_flags[FLAG_NAN] = 1'b1;
    end else if (acc_inf) begin
      nxt_acc = acc;
    end else if (prd_inf) begin
      nxt_acc = {prd_s, FP32_PINF[30:0]};
    end else if ((sum == '0) || (res_exp <= 10'sd0)) begin
      nxt_acc = '0;
    end else if (res_exp >= 10'sd255) begin
      nxt_acc             = FP32_PINF | {al_sign, 31'b0};
      nxt_flags[FLAG_OVF] = 1'b1;
      nxt_flags[FLAG_INF] = 1'b1;
    end else begin
      nxt_acc = {al_sign, res_exp[7:0], frac};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT;
    else        state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      S_WAIT:  if (in_valid) nxt_state = S_ALIGN;
      S_ALIGN: nxt_state = S_NORM;
      S_NORM:  nxt_state = last_q ? S_OUT : S_WAIT;
      S_OUT:   if (out_ready) nxt_state = S_WAIT;
      default: nxt_state = S_WAIT;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == S_WAIT);
    out_valid = (state == S_OUT);
  end

  assign out_sum   = acc;
  assign out_count = count;
  assign out_flags = flags;

  // Datapath registers: capture, align, accumulate, clear on hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pab_q   <= '0;
      last_q  <= 1'b0;
      acc     <= '0;
      count   <= '0;
      flags   <= '0;
      al_big  <= '0;
      al_sml  <= '0;
      al_exp  <= '0;
      al_sign <= 1'b0;
      al_sub  <= 1'b0;
    end else begin
      case (state)
        S_WAIT: if (in_valid) begin
          pab_q  <= in_pab;
          last_q <= in_last;
        end
        S_ALIGN: begin
          al_big  <= {big_m, 3'b000};
          al_sml  <= sml_sh;
          al_exp  <= big_e;
          al_sign <= acc_big ? acc_s : prd_s;
          al_sub  <= acc_s ^ prd_s;
        end
        S_NORM: begin
          acc   <= nxt_acc;
          flags <= nxt_flags;
          count <= (count == '1) ? count : count + 1'b1;
        end
        S_OUT: if (out_ready) begin
          acc    <= '0;
          count  <= '0;
          flags  <= '0;
          last_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_format9_madd_accum.sv
// Directed bench for format9_madd_accum with hand-computed FP32 results.
module tb_format9_madd_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pab;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic [2:0]  out_flags;

  int total = 0;
  int bad   = 0;

  format9_madd_accum #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pab    (in_pab),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Present one product and return 1ns after the edge that accepts it
  task automatic send(input logic [15:0] p, input logic l);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready=%b want=1", in_ready);
    end
    in_valid = 1'b1; in_pab = p; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Wait (bounded) for a result, capture it, then take it with out_ready
  task automatic get_result(output logic [31:0] s, output logic [15:0] c,
                            output logic [2:0] f);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL result_timeout out_valid=%b want=1", out_valid);
    end
    s = out_sum; c = out_count; f = out_flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    total++; if (out_sum !== 32'h0) begin bad++; $display("FAIL rst_sum got=%h want=00000000", out_sum); end
    total++; if (out_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", out_count); end
    total++; if (out_flags !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", out_flags); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    // accept edge is edge 0: out_valid seen low at edge 2, high at edge 3
    @(negedge clk); @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_edge3 got=%b want=1", out_valid); end
    get_result(s, c, f);
    total++; if (s !== 32'h40400000) begin bad++; $display("FAIL basic_sum got=%h want=40400000", s); end
    total++; if (c !== 16'd2) begin bad++; $display("FAIL basic_count got=%0d want=2", c); end
    total++; if (f !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", f); end
  endtask

  task automatic test_cancel();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    send(16'h3F80, 1'b0); send(16'hBF80, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h00000000) begin bad++; $display("FAIL cancel_sum got=%h want=00000000", s); end
    send(16'h3FC0, 1'b0); send(16'h4040, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h40900000) begin bad++; $display("FAIL mixed_sum got=%h want=40900000", s); end
    // 3.0 + (-1.0) = 2.0 through the subtract path
    send(16'h4040, 1'b0); send(16'hBF80, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h40000000) begin bad++; $display("FAIL sub_sum got=%h want=40000000", s); end
  endtask

  task automatic test_nan();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    send(16'h7FC0, 1'b0); send(16'h3F80, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h7FC00000) begin bad++; $display("FAIL nan_sum got=%h want=7fc00000", s); end
    total++; if (c !== 16'd2) begin bad++; $display("FAIL nan_count got=%0d want=2", c); end
    total++; if (f !== 3'b100) begin bad++; $display("FAIL nan_flags got=%b want=100", f); end
    send(16'h7F80, 1'b0); send(16'hFF80, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h7FC00000) begin bad++; $display("FAIL infinf_sum got=%h want=7fc00000", s); end
    total++; if (f !== 3'b110) begin bad++; $display("FAIL infinf_flags got=%b want=110", f); end
  endtask

  task automatic test_overflow();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    send(16'h7F7F, 1'b0); send(16'h7F7F, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h7F800000) begin bad++; $display("FAIL ovf_sum got=%h want=7f800000", s); end
    total++; if (f !== 3'b011) begin bad++; $display("FAIL ovf_flags got=%b want=011", f); end
    send(16'h0000, 1'b0); send(16'h0012, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h00000000) begin bad++; $display("FAIL zero_sum got=%h want=00000000", s); end
    total++; if (f !== 3'b000) begin bad++; $display("FAIL zero_flags got=%b want=000", f); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    send(16'h3F80, 1'b0); send(16'h3F80, 1'b0); send(16'h3F80, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h40400000) begin bad++; $display("FAIL three_sum got=%h want=40400000", s); end
    total++; if (c !== 16'd3) begin bad++; $display("FAIL three_count got=%0d want=3", c); end
    // 2^24 + 1.0 truncates back to 2^24
    send(16'h4B80, 1'b0); send(16'h3F80, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h4B800000) begin bad++; $display("FAIL rtz_sum got=%h want=4b800000", s); end
    send(16'hC000, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'hC0000000) begin bad++; $display("FAIL single_neg got=%h want=c0000000", s); end
    total++; if (c !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", c); end
  endtask

  task automatic test_backpressure();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    int n = 0;
    send(16'h4000, 1'b1);
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    in_valid = 1'b1; in_pab = 16'h3F80; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", i, out_valid); end
      total++; if (out_sum !== 32'h40000000) begin bad++; $display("FAIL bp_sum cyc=%0d got=%h want=40000000", i, out_sum); end
      total++; if (out_count !== 16'd1) begin bad++; $display("FAIL bp_count cyc=%0d got=%0d want=1", i, out_count); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    send(16'h3FC0, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h3FC00000) begin bad++; $display("FAIL bp_next_sum got=%h want=3fc00000", s); end
    total++; if (c !== 16'd1) begin bad++; $display("FAIL bp_next_count got=%0d want=1", c); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s; logic [15:0] c; logic [2:0] f;
    send(16'h3F80, 1'b0);
    @(posedge clk); #2;           // now in S_NORM
    rst_n = 1'b0;
    #1;                           // no clock edge in between
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b want=0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    send(16'h4000, 1'b1);
    get_result(s, c, f);
    total++; if (s !== 32'h40000000) begin bad++; $display("FAIL mid_sum got=%h want=40000000", s); end
    total++; if (c !== 16'd1) begin bad++; $display("FAIL mid_count got=%0d want=1", c); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_pab = 16'h0; in_last = 1'b0; out_ready = 1'b0;
    test_reset();
    test_basic_sum();
    test_cancel();
    test_nan();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
